// File: rtl/fc_layer_sequencer_if.sv
// Memory-side bundle of the FC layer sequencer: weight/activation read ports,
// output write port and the start/status handshake.
interface fc_layer_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              start;
    logic              relu_en;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [ADDR_W-1:0] x_addr;
    logic [DATA_W-1:0] x_data;
    logic [ADDR_W-1:0] y_addr;
    logic [DATA_W-1:0] y_data;
    logic              y_we;
    logic              busy;
    logic              done;
    logic              sat;

    modport master (
        input  start, relu_en, w_data, x_data,
        output w_addr, x_addr, y_addr, y_data, y_we, busy, done, sat
    );

    modport slave (
        output start, relu_en, w_data, x_data,
        input  w_addr, x_addr, y_addr, y_data, y_we, busy, done, sat
    );
endinterface

// File: rtl/fc_layer_sequencer.sv
// One fully-connected layer pass: row-major MAC over the weight ROM, then
// rescale, saturate, optional ReLU and write one output per neuron.
module fc_layer_sequencer #(
    parameter int IN_DIM    = 32,
    parameter int OUT_DIM   = 10,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int ACC_W     = 64,
    parameter int FRAC_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    fc_layer_sequencer_if.master  bus
);

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(IN_DIM - 1);
    localparam logic [ADDR_W-1:0] LAST_O = ADDR_W'(OUT_DIM - 1);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

    state_t                   state, state_nx;
    logic [ADDR_W-1:0]        i, o;
    logic signed [ACC_W-1:0]  acc, prod, sum, shifted;
    logic [ACC_W-DATA_W:0]    hi;
    logic [DATA_W-1:0]        fval;
    logic                     fsat;
    logic                     relu_q;

    // Final MAC sum is scaled and written on the same edge that ends the row,
    // so y_we/y_data are registered and visible throughout the WRITE cycle.
    always_comb begin
        prod    = {{(ACC_W-DATA_W){bus.w_data[DATA_W-1]}}, bus.w_data} *
                  {{(ACC_W-DATA_W){bus.x_data[DATA_W-1]}}, bus.x_data};
        sum     = acc + prod;
        shifted = sum >>> FRAC_BITS;
        hi      = shifted[ACC_W-1:DATA_W-1];
        fsat    = !((&hi) || !(|hi));
        fval    = shifted[DATA_W-1:0];
        if (fsat)
            fval = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                    : {1'b0, {(DATA_W-1){1'b1}}};
        if (relu_q && fval[DATA_W-1])
            fval = '0;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = MAC;
            MAC:     if (i == LAST_I) state_nx = WRITE;
            WRITE:   state_nx = (o == LAST_O) ? DONE : MAC;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.w_addr <= '0;
            bus.x_addr <= '0;
            bus.y_addr <= '0;
            bus.y_data <= '0;
            bus.y_we   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.sat    <= 1'b0;
            acc        <= '0;
            i          <= '0;
            o          <= '0;
            relu_q     <= 1'b0;
        end else begin
            bus.busy <= (state_nx != IDLE);
            bus.done <= (state_nx == DONE);
            bus.y_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        i          <= '0;
                        o          <= '0;
                        acc        <= '0;
                        bus.w_addr <= '0;
                        bus.x_addr <= '0;
                        bus.sat    <= 1'b0;
                        relu_q     <= bus.relu_en;
                    end
                end
                MAC: begin
                    if (i == LAST_I) begin
                        acc        <= '0;
                        bus.y_we   <= 1'b1;
                        bus.y_addr <= o;
                        bus.y_data <= fval;
                        if (fsat) bus.sat <= 1'b1;
                    end else begin
                        acc        <= sum;
                        i          <= i + ONE;
                        bus.w_addr <= bus.w_addr + ONE;
                        bus.x_addr <= bus.x_addr + ONE;
                    end
                end
                WRITE: begin
                    if (o != LAST_O) begin
                        o          <= o + ONE;
                        i          <= '0;
                        bus.x_addr <= '0;
                        // Held address is o*IN_DIM+IN_DIM-1, so +1 is the next row base.
                        bus.w_addr <= bus.w_addr + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Self-checking bench for fc_layer_sequencer: directed and random layer passes
// compared against an arithmetic model of y = f(W*x).
module tb_fc_layer_sequencer;

    localparam int IN_DIM  = 32;
    localparam int OUT_DIM = 10;
    localparam int PERIOD  = IN_DIM + 1;
    localparam int PASS_LEN = OUT_DIM * PERIOD + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fc_layer_sequencer_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    fc_layer_sequencer #(
        .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .ADDR_W(16),
        .DATA_W(32), .ACC_W(64), .FRAC_BITS(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic [31:0] wmem [IN_DIM*OUT_DIM];
    logic [31:0] xmem [IN_DIM];

    assign bus.w_data = (int'(bus.w_addr) < IN_DIM*OUT_DIM) ? wmem[bus.w_addr] : 32'hx;
    assign bus.x_data = (int'(bus.x_addr) < IN_DIM) ? xmem[bus.x_addr] : 32'hx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          wq_cyc [$];
    logic [15:0] wq_addr [$];
    logic [31:0] wq_data [$];
    int          dq [$];
    int          pass_t = 0;
    bit          trace_en = 0;
    bit          trace_bad = 0;
    int          md, mrow, mcol;

    always @(negedge clk) begin
        if (bus.y_we === 1'b1) begin
            wq_cyc.push_back(cyc);
            wq_addr.push_back(bus.y_addr);
            wq_data.push_back(bus.y_data);
        end
        if (bus.done === 1'b1) dq.push_back(cyc);
        if (trace_en) begin
            md = cyc - pass_t;
            if (md >= 1 && md <= OUT_DIM * PERIOD) begin
                mrow = (md - 1) / PERIOD;
                mcol = (md - 1) % PERIOD;
                if (mcol == IN_DIM) mcol = IN_DIM - 1;
                if (int'(bus.w_addr) != mrow * IN_DIM + mcol || int'(bus.x_addr) != mcol)
                    trace_bad = 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: y[o] = sat32((sum_i W[o][i]*x[i]) >>> 16), then ReLU.
    logic [31:0] exp_y [OUT_DIM];
    bit          exp_sat;

    task automatic model(input bit relu);
        longint acc, s;
        logic [31:0] r;
        exp_sat = 0;
        for (int oo = 0; oo < OUT_DIM; oo++) begin
            acc = 0;
            for (int ii = 0; ii < IN_DIM; ii++)
                acc += longint'($signed(wmem[oo*IN_DIM+ii])) * longint'($signed(xmem[ii]));
            s = acc >>> 16;
            if (s > 64'sd2147483647) begin
                r = 32'h7FFFFFFF; exp_sat = 1;
            end else if (s < -64'sd2147483648) begin
                r = 32'h80000000; exp_sat = 1;
            end else begin
                r = s[31:0];
            end
            if (relu && r[31]) r = '0;
            exp_y[oo] = r;
        end
    endtask

    task automatic clear_mon();
        wq_cyc.delete(); wq_addr.delete(); wq_data.delete(); dq.delete();
    endtask

    task automatic run_pass(input string name, input bit relu, input bit trace);
        int n;
        model(relu);
        @(negedge clk);
        clear_mon();
        pass_t = cyc;
        trace_bad = 0;
        trace_en = trace;
        bus.start = 1'b1;
        bus.relu_en = relu;
        @(negedge clk);
        bus.start = 1'b0;
        bus.relu_en = 1'($urandom);
        check({name, ".sat_clr"}, bus.sat, 1'b0);
        check({name, ".busy"}, bus.busy, 1'b1);
        for (int k = 0; k < PASS_LEN + 40 && dq.size() == 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        trace_en = 0;
        check({name, ".done_cnt"}, dq.size(), 1);
        if (dq.size() > 0) check({name, ".done_cyc"}, dq[0], pass_t + PASS_LEN);
        check({name, ".nwrites"}, wq_cyc.size(), OUT_DIM);
        n = (wq_cyc.size() < OUT_DIM) ? wq_cyc.size() : OUT_DIM;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s.y%0d_cyc", name, k), wq_cyc[k], pass_t + (k + 1) * PERIOD);
            check($sformatf("%s.y%0d_addr", name, k), wq_addr[k], k);
            check($sformatf("%s.y%0d_data", name, k), wq_data[k], exp_y[k]);
        end
        check({name, ".sat"}, bus.sat, exp_sat);
        check({name, ".idle"}, bus.busy, 1'b0);
        if (trace) check({name, ".trace"}, trace_bad, 1'b0);
    endtask

    task automatic fill(input logic [31:0] w, input logic [31:0] x);
        for (int k = 0; k < IN_DIM*OUT_DIM; k++) wmem[k] = w;
        for (int k = 0; k < IN_DIM; k++) xmem[k] = x;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.relu_en = 1'b0;
        fill(32'h0, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst.w_addr", bus.w_addr, 16'h0);
        check("rst.x_addr", bus.x_addr, 16'h0);
        check("rst.y_addr", bus.y_addr, 16'h0);
        check("rst.y_data", bus.y_data, 32'h0);
        check("rst.ctrl", {bus.y_we, bus.busy, bus.done, bus.sat}, 4'b0000);

        fill(32'h00010000, 32'h00010000);
        run_pass("unit", 1'b0, 1'b1);

        fill(32'hFFFF0000, 32'h00010000);
        run_pass("neg", 1'b0, 1'b0);
        run_pass("neg_relu", 1'b1, 1'b0);

        fill(32'h40000000, 32'h00400000);
        run_pass("satp", 1'b0, 1'b0);
        fill(32'h00010000, 32'h00010000);
        run_pass("after_sat", 1'b0, 1'b0);

        for (int oo = 0; oo < OUT_DIM; oo++)
            for (int ii = 0; ii < IN_DIM; ii++) wmem[oo*IN_DIM+ii] = (oo + 1) << 16;
        run_pass("rows", 1'b0, 1'b1);

        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < IN_DIM*OUT_DIM; k++)
                wmem[k] = (r < 2) ? 32'($signed($urandom_range(0, 2**21)) - 2**20) : $urandom;
            for (int k = 0; k < IN_DIM; k++)
                xmem[k] = (r < 2) ? 32'($signed($urandom_range(0, 2**21)) - 2**20) : $urandom;
            run_pass($sformatf("rnd%0d", r), 1'($urandom), 1'b0);
        end

        // Mid-pass start is ignored; reset aborts the pass cleanly.
        fill(32'h00010000, 32'h00010000);
        model(1'b0);
        @(negedge clk);
        clear_mon();
        pass_t = cyc;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < pass_t + 10) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < pass_t + 100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort.nwrites", wq_cyc.size(), 3);
        for (int k = 0; k < 3 && k < wq_cyc.size(); k++) begin
            check($sformatf("abort.y%0d_cyc", k), wq_cyc[k], pass_t + (k + 1) * PERIOD);
            check($sformatf("abort.y%0d_data", k), wq_data[k], exp_y[k]);
        end
        check("abort.addrs", {bus.w_addr, bus.x_addr, bus.y_addr}, 48'h0);
        check("abort.y_data", bus.y_data, 32'h0);
        check("abort.ctrl", {bus.y_we, bus.busy, bus.done, bus.sat}, 4'b0000);
        clear_mon();
        repeat (PASS_LEN + 20) @(negedge clk);
        check("abort.no_we", wq_cyc.size(), 0);
        check("abort.no_done", dq.size(), 0);
        run_pass("fresh", 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
